// File: rtl/calc2_pkg.sv
// Shared types and constants for the Calc2 port driver and its tag tracker.
// Vectors use ascending ranges so that bit i always corresponds to tag i.
package calc2_pkg;

    typedef enum logic [0:3] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_t;

    typedef enum logic [0:1] {
        NONE    = 2'd0,
        GOOD    = 2'd1,
        ERR_OVF = 2'd2,
        ERR_INT = 2'd3
    } resp_t;

    typedef logic [0:1] tag_t;

    localparam int NUM_TAGS = 4;
    localparam int AGE_W    = 6;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic tag_t lowest_set(input logic [0:NUM_TAGS-1] v);
        lowest_set = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = tag_t'(i);
        end
    endfunction

endpackage

// File: rtl/calc2_tag_tracker.sv
// Outstanding-tag bookkeeping: busy vector, per-tag age counters,
// lowest-free allocation and lowest-expired timeout selection.
module calc2_tag_tracker
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic                retire_en,
    input  tag_t                retire_tag,
    output logic [0:NUM_TAGS-1] busy,
    output tag_t                free_tag,
    output logic                all_busy,
    output logic                to_valid,
    output tag_t                to_tag
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    logic [AGE_W-1:0]    age [NUM_TAGS];
    logic [0:NUM_TAGS-1] expired;

    always_comb begin
        expired = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            expired[i] = busy[i] && (age[i] == AGE_MAX);
        end
    end

    assign free_tag = lowest_set(~busy);
    assign all_busy = &busy;
    assign to_tag   = lowest_set(expired);
    // A real response in the same cycle holds every pending timeout back.
    assign to_valid = (|expired) && !retire_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (alloc_en && (free_tag == tag_t'(i))) begin
                    busy[i] <= 1'b1;
                    age[i]  <= '0;
                end else if ((retire_en && (retire_tag == tag_t'(i))) ||
                             (to_valid && (to_tag == tag_t'(i)))) begin
                    busy[i] <= 1'b0;
                    age[i]  <= '0;
                end else if (busy[i] && (age[i] != AGE_MAX)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc2_port_driver.sv
// Request adapter for one Calc2 port: tags each request, drives the
// two-beat command/data sequence and returns responses or timeouts.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | beat 1 of an accepted request is registered on exit
//   SEND_OP2 | beat 1 is on the port; beat 2 is registered on exit
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          resetInt,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [0:3]    req_cmd,
    input  logic [0:31]   req_op1,
    input  logic [0:31]   req_op2,
    output logic [0:3]    reg_cmd_in,
    output logic [0:31]   reg_data_in,
    output logic [0:1]    reg_tag_in,
    input  logic [0:1]    out_resp,
    input  logic [0:31]   out_data,
    input  logic [0:1]    out_tag,
    output logic          rsp_valid,
    output logic [0:1]    rsp_code,
    output logic [0:31]   rsp_data,
    output logic [0:1]    rsp_tag,
    output logic          rsp_timeout,
    output logic          err_spurious,
    output logic [0:3]    busy_tags
);

    typedef enum logic {IDLE, SEND_OP2} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        all_busy;
    logic        resp_hit;
    logic        resp_spurious;
    logic        to_valid;
    tag_t        to_tag;
    tag_t        free_tag;
    tag_t        tag_q;
    logic [0:31] op2_q;
    logic [0:3]  cmd_nxt;
    logic [0:31] data_nxt;
    tag_t        tag_nxt;

    // Gated by reset so the requester never sees ready while in reset.
    assign req_ready     = (state == IDLE) && !all_busy && !resetInt;
    assign accept        = req_valid && req_ready;
    assign resp_hit      = (out_resp != NONE) && busy_tags[out_tag];
    assign resp_spurious = (out_resp != NONE) && !busy_tags[out_tag];

    calc2_tag_tracker #(
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .clk        (clk),
        .rst        (resetInt),
        .alloc_en   (accept),
        .retire_en  (resp_hit),
        .retire_tag (out_tag),
        .busy       (busy_tags),
        .free_tag   (free_tag),
        .all_busy   (all_busy),
        .to_valid   (to_valid),
        .to_tag     (to_tag)
    );

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        data_nxt  = '0;
        tag_nxt   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND_OP2;
                    cmd_nxt   = req_cmd;
                    data_nxt  = req_op1;
                    tag_nxt   = free_tag;
                end
            end
            SEND_OP2: begin
                state_nxt = IDLE;
                cmd_nxt   = NOP;
                data_nxt  = op2_q;
                tag_nxt   = tag_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) begin
            reg_cmd_in  <= '0;
            reg_data_in <= '0;
            reg_tag_in  <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
        end else begin
            reg_cmd_in  <= cmd_nxt;
            reg_data_in <= data_nxt;
            reg_tag_in  <= tag_nxt;
            if (accept) begin
                op2_q <= req_op2;
                tag_q <= free_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) begin
            rsp_valid    <= 1'b0;
            rsp_code     <= '0;
            rsp_data     <= '0;
            rsp_tag      <= '0;
            rsp_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            err_spurious <= resp_spurious;
            if (resp_hit) begin
                rsp_valid   <= 1'b1;
                rsp_code    <= out_resp;
                rsp_data    <= out_data;
                rsp_tag     <= out_tag;
                rsp_timeout <= 1'b0;
            end else if (to_valid) begin
                rsp_valid   <= 1'b1;
                rsp_code    <= ERR_INT;
                rsp_data    <= '0;
                rsp_tag     <= to_tag;
                rsp_timeout <= 1'b1;
            end else begin
                rsp_valid   <= 1'b0;
                rsp_code    <= '0;
                rsp_data    <= '0;
                rsp_tag     <= '0;
                rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc2_port_driver.sv
// Directed bench for calc2_port_driver with TIMEOUT = 10.
module tb_calc2_port_driver;

    logic        clk = 1'b0;
    logic        resetInt;
    logic        req_valid;
    logic        req_ready;
    logic [0:3]  req_cmd;
    logic [0:31] req_op1;
    logic [0:31] req_op2;
    logic [0:3]  reg_cmd_in;
    logic [0:31] reg_data_in;
    logic [0:1]  reg_tag_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic [0:1]  out_tag;
    logic        rsp_valid;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic [0:1]  rsp_tag;
    logic        rsp_timeout;
    logic        err_spurious;
    logic [0:3]  busy_tags;

    int vecs = 0;
    int miscompares = 0;
    int n;

    always #5 clk = ~clk;

    calc2_port_driver #(.TIMEOUT(10)) dut (
        .clk          (clk),
        .resetInt     (resetInt),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .reg_cmd_in   (reg_cmd_in),
        .reg_data_in  (reg_data_in),
        .reg_tag_in   (reg_tag_in),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .rsp_valid    (rsp_valid),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_timeout  (rsp_timeout),
        .err_spurious (err_spurious),
        .busy_tags    (busy_tags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetInt  = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_op1   = '0;
        req_op2   = '0;
        out_resp  = '0;
        out_data  = '0;
        out_tag   = '0;
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_reg_cmd", reg_cmd_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy_tags, 0);
        tick();
        tick();
        resetInt = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);

        // Single ADD 5 + 7, answered with 12 on tag 0
        req_valid = 1'b1;
        req_cmd   = 4'd1;
        req_op1   = 32'd5;
        req_op2   = 32'd7;
        tick();
        req_valid = 1'b0;
        check("b1_cmd", reg_cmd_in, 1);
        check("b1_data", reg_data_in, 5);
        check("b1_tag", reg_tag_in, 0);
        check("b1_busy", busy_tags, 4'b1000);
        check("b1_ready", req_ready, 0);
        tick();
        check("b2_cmd", reg_cmd_in, 0);
        check("b2_data", reg_data_in, 7);
        check("b2_tag", reg_tag_in, 0);
        tick();
        check("idle_data", reg_data_in, 0);
        out_resp = 2'b01;
        out_data = 32'd12;
        out_tag  = 2'd0;
        tick();
        out_resp = 2'b00;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_code", rsp_code, 1);
        check("rsp_data", rsp_data, 12);
        check("rsp_tag", rsp_tag, 0);
        check("rsp_to", rsp_timeout, 0);
        check("rsp_busy", busy_tags, 4'b0000);
        tick();
        check("rsp_pulse", rsp_valid, 0);

        // Four back-to-back requests exhaust the tags
        req_valid = 1'b1;
        req_cmd   = 4'd6;
        req_op1   = 32'hA0;
        req_op2   = 32'hB0;
        check("b2b_ready0", req_ready, 1);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("b2b_tag", reg_tag_in, t);
            tick();
        end
        check("full_ready", req_ready, 0);
        check("full_busy", busy_tags, 4'b1111);
        out_resp = 2'b01;
        out_data = 32'd99;
        out_tag  = 2'd2;
        tick();
        out_resp = 2'b00;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_tag", rsp_tag, 2);
        check("t2_busy", busy_tags, 4'b1101);
        check("t2_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("realloc_tag", reg_tag_in, 2);
        check("realloc_busy", busy_tags, 4'b1111);

        // Reset between beat 1 and beat 2
        resetInt = 1'b1;
        #1;
        check("mid_rst_cmd", reg_cmd_in, 0);
        check("mid_rst_data", reg_data_in, 0);
        check("mid_rst_busy", busy_tags, 0);
        check("mid_rst_ready", req_ready, 0);
        tick();
        resetInt = 1'b0;
        tick();
        check("no_beat2_data", reg_data_in, 0);
        check("no_beat2_tag", reg_tag_in, 0);
        check("no_rsp_after_rst", rsp_valid, 0);

        // Response for a tag that is not outstanding
        out_resp = 2'b10;
        out_tag  = 2'd3;
        out_data = 32'h77;
        tick();
        out_resp = 2'b00;
        check("spur_pulse", err_spurious, 1);
        check("spur_no_rsp", rsp_valid, 0);
        tick();
        check("spur_clear", err_spurious, 0);

        // Timeout: counter is 0 the cycle after acceptance and reaches 10
        // eleven cycles after acceptance; the retire shows one cycle later.
        req_valid = 1'b1;
        req_cmd   = 4'd1;
        req_op1   = 32'd1;
        req_op2   = 32'd2;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 12);
        check("to_valid", rsp_valid, 1);
        check("to_flag", rsp_timeout, 1);
        check("to_code", rsp_code, 3);
        check("to_tag", rsp_tag, 0);
        check("to_data", rsp_data, 0);
        check("to_busy", busy_tags, 0);

        // Tag 1 expires in the cycle a real response for tag 0 arrives
        req_valid = 1'b1;
        req_cmd   = 4'd2;
        req_op1   = 32'd9;
        req_op2   = 32'd3;
        tick();
        check("co_tag0", reg_tag_in, 0);
        tick();
        tick();
        req_valid = 1'b0;
        check("co_tag1", reg_tag_in, 1);
        out_resp = 2'b01;
        out_tag  = 2'd0;
        out_data = 32'h11;
        tick();
        out_resp  = 2'b00;
        req_valid = 1'b1;
        check("co_first_rsp", rsp_tag, 0);
        tick();
        req_valid = 1'b0;
        check("co_realloc", reg_tag_in, 0);
        check("co_busy", busy_tags, 4'b1100);
        repeat (8) tick();
        check("co_pre_rsp", rsp_valid, 0);
        out_resp = 2'b01;
        out_tag  = 2'd0;
        out_data = 32'h55;
        tick();
        out_resp = 2'b00;
        check("co_real_valid", rsp_valid, 1);
        check("co_real_tag", rsp_tag, 0);
        check("co_real_to", rsp_timeout, 0);
        check("co_real_data", rsp_data, 32'h55);
        tick();
        check("co_to_valid", rsp_valid, 1);
        check("co_to_tag", rsp_tag, 1);
        check("co_to_flag", rsp_timeout, 1);
        check("co_to_code", rsp_code, 3);
        tick();
        check("co_end_valid", rsp_valid, 0);
        check("co_end_busy", busy_tags, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
